// File: rtl/lsu_axi_master_if.sv
// AXI4 single-master bus bundle used by the load/store unit.
// Handshake rule on every channel: a transfer happens on a rising edge where valid and ready are both high.
// The source holds valid and the payload stable until that edge, and ready may depend on valid.
interface lsu_axi_master_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4
);
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_W-1:0]     awaddr;
  logic [ID_W-1:0]       awid;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;

  logic                  wvalid;
  logic                  wready;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  wlast;

  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;
  logic [ID_W-1:0]       bid;

  logic                  arvalid;
  logic                  arready;
  logic [ADDR_W-1:0]     araddr;
  logic [ID_W-1:0]       arid;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;

  logic                  rvalid;
  logic                  rready;
  logic [DATA_W-1:0]     rdata;
  logic [1:0]            rresp;
  logic [ID_W-1:0]       rid;
  logic                  rlast;

  modport master (
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp, bid,
    output bready,
    output arvalid, araddr, arid, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rdata, rresp, rid, rlast,
    output rready
  );

  modport slave (
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp, bid,
    input  bready,
    input  arvalid, araddr, arid, arlen, arsize, arburst,
    output arready,
    output rvalid, rdata, rresp, rid, rlast,
    input  rready
  );
endinterface

// File: rtl/lsu_axi_master.sv
// Load/store unit: turns one EXU memory request into a single-beat AXI4 transaction,
// steering bytes into lanes and reporting alignment, bus-response and ID errors.
module lsu_axi_master #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              req_wen,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [1:0]        resp_err,
  output logic [2:0]        dbg_state,
  lsu_axi_master_if.master  io_master
);
  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam logic [1:0] MAX_SIZE = 2'(LSB);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_WB, S_RA, S_RD, S_ERR} state_e;

  state_e              state, state_nx;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   strb_q, strb_nx;
  logic [1:0]          size_q;
  logic                uns_q;
  logic [LSB-1:0]      lane_q, lane, align_mask;
  logic [ID_W-1:0]     cur_id;
  logic                aw_done, w_done;
  logic                accept, legal;
  logic                resp_fire;
  logic [1:0]          resp_err_nx;
  logic [DATA_W-1:0]   resp_rdata_nx;
  logic [DATA_W-1:0]   rshift, keep, load_ext;
  logic                sign;
  logic                unused_rlast;

  assign unused_rlast = io_master.rlast;
  assign dbg_state    = state;

  assign lane       = req_addr[LSB-1:0];
  assign align_mask = LSB'((32'd1 << req_size) - 32'd1);
  assign legal      = (req_size <= MAX_SIZE) && ((lane & align_mask) == '0);
  assign accept     = req_valid && req_ready;

  // Byte-enable window: 2^size lanes starting at the address lane.
  always_comb begin
    strb_nx = '0;
    for (int i = 0; i < STRB_W; i++)
      strb_nx[i] = (i >= int'(lane)) && (i < int'(lane) + (1 << req_size));
  end

  assign io_master.awaddr  = addr_q;
  assign io_master.awid    = cur_id;
  assign io_master.awlen   = 8'd0;
  assign io_master.awsize  = {1'b0, size_q};
  assign io_master.awburst = 2'b01;
  assign io_master.wdata   = wdata_q;
  assign io_master.wstrb   = strb_q;
  assign io_master.wlast   = 1'b1;
  assign io_master.araddr  = addr_q;
  assign io_master.arid    = cur_id;
  assign io_master.arlen   = 8'd0;
  assign io_master.arsize  = {1'b0, size_q};
  assign io_master.arburst = 2'b01;

  always_comb begin
    state_nx          = state;
    io_master.awvalid = 1'b0;
    io_master.wvalid  = 1'b0;
    io_master.bready  = 1'b0;
    io_master.arvalid = 1'b0;
    io_master.rready  = 1'b0;
    case (state)
      S_IDLE: if (accept) state_nx = !legal ? S_ERR : (req_wen ? S_WR : S_RA);
      S_WR: begin
        // AW and W complete independently; leave once both have handshaken.
        io_master.awvalid = !aw_done;
        io_master.wvalid  = !w_done;
        if ((aw_done || io_master.awready) && (w_done || io_master.wready))
          state_nx = S_WB;
      end
      S_WB: begin
        io_master.bready = 1'b1;
        if (io_master.bvalid) state_nx = S_IDLE;
      end
      S_RA: begin
        io_master.arvalid = 1'b1;
        if (io_master.arready) state_nx = S_RD;
      end
      S_RD: begin
        io_master.rready = 1'b1;
        if (io_master.rvalid) state_nx = S_IDLE;
      end
      S_ERR:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Bring the addressed bytes down to bit 0, then extend from the top byte of the access.
  always_comb begin
    rshift = io_master.rdata >> {lane_q, 3'b000};
    keep   = '0;
    sign   = 1'b0;
    for (int i = 0; i < STRB_W; i++) begin
      if (i < (1 << size_q)) keep[8*i +: 8] = 8'hFF;
      if (i == (1 << size_q) - 1) sign = rshift[8*i+7];
    end
    load_ext = rshift & keep;
    if (!uns_q && sign) load_ext = load_ext | ~keep;
  end

  function automatic logic [1:0] bus_err(input logic [ID_W-1:0] id, input logic [ID_W-1:0] exp_id,
                                         input logic [1:0] resp);
    if (id != exp_id)      return 2'b11;
    else if (resp != 2'b00) return 2'b10;
    else                    return 2'b00;
  endfunction

  always_comb begin
    resp_fire     = 1'b0;
    resp_err_nx   = 2'b00;
    resp_rdata_nx = '0;
    case (state)
      S_WB: if (io_master.bvalid) begin
        resp_fire   = 1'b1;
        resp_err_nx = bus_err(io_master.bid, cur_id, io_master.bresp);
      end
      S_RD: if (io_master.rvalid) begin
        resp_fire   = 1'b1;
        resp_err_nx = bus_err(io_master.rid, cur_id, io_master.rresp);
        if (resp_err_nx == 2'b00) resp_rdata_nx = load_ext;
      end
      S_ERR: begin
        resp_fire   = 1'b1;
        resp_err_nx = 2'b01;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 2'b00;
      resp_rdata <= '0;
      cur_id     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      lane_q     <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
    end else begin
      state      <= state_nx;
      // Ready is withheld during the response pulse so completions never overlap new requests.
      req_ready  <= (state_nx == S_IDLE) && !resp_fire;
      resp_valid <= resp_fire;
      resp_err   <= resp_err_nx;
      resp_rdata <= resp_rdata_nx;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata << {lane, 3'b000};
        strb_q  <= strb_nx;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        lane_q  <= lane;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        if (legal) cur_id <= cur_id + 1'b1;
      end
      if (state == S_WR) begin
        if (io_master.awready) aw_done <= 1'b1;
        if (io_master.wready)  w_done  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_lsu_axi_master.sv
// Bench for lsu_axi_master: one 32-bit and one 64-bit instance share the stimulus,
// a select picks which one is exercised, and a byte-arithmetic model predicts every result.
module tb_lsu_axi_master;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        sel64;
  logic        req_valid, req_wen, req_unsigned;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_size;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [3:0]  bid, rid;
  logic [63:0] rdata;

  logic        req_ready32, req_ready64, resp_valid32, resp_valid64;
  logic [31:0] resp_rdata32;
  logic [63:0] resp_rdata64;
  logic [1:0]  resp_err32, resp_err64;
  logic [2:0]  unused_dbg32, unused_dbg64;

  lsu_axi_master_if #(.DATA_W(32), .ADDR_W(32), .ID_W(4)) bus32 ();
  lsu_axi_master_if #(.DATA_W(64), .ADDR_W(32), .ID_W(4)) bus64 ();

  assign bus32.awready = awready;  assign bus64.awready = awready;
  assign bus32.wready  = wready;   assign bus64.wready  = wready;
  assign bus32.bvalid  = bvalid;   assign bus64.bvalid  = bvalid;
  assign bus32.bresp   = bresp;    assign bus64.bresp   = bresp;
  assign bus32.bid     = bid;      assign bus64.bid     = bid;
  assign bus32.arready = arready;  assign bus64.arready = arready;
  assign bus32.rvalid  = rvalid;   assign bus64.rvalid  = rvalid;
  assign bus32.rdata   = rdata[31:0];
  assign bus64.rdata   = rdata;
  assign bus32.rresp   = rresp;    assign bus64.rresp   = rresp;
  assign bus32.rid     = rid;      assign bus64.rid     = rid;
  assign bus32.rlast   = 1'b1;     assign bus64.rlast   = 1'b1;

  lsu_axi_master #(.DATA_W(32), .ADDR_W(32), .ID_W(4)) u_dut32 (
    .clock(clock), .reset(reset), .req_valid(req_valid && !sel64), .req_ready(req_ready32),
    .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .req_wen(req_wen), .req_size(req_size),
    .req_unsigned(req_unsigned), .resp_valid(resp_valid32), .resp_rdata(resp_rdata32),
    .resp_err(resp_err32), .dbg_state(unused_dbg32), .io_master(bus32)
  );

  lsu_axi_master #(.DATA_W(64), .ADDR_W(32), .ID_W(4)) u_dut64 (
    .clock(clock), .reset(reset), .req_valid(req_valid && sel64), .req_ready(req_ready64),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wen(req_wen), .req_size(req_size),
    .req_unsigned(req_unsigned), .resp_valid(resp_valid64), .resp_rdata(resp_rdata64),
    .resp_err(resp_err64), .dbg_state(unused_dbg64), .io_master(bus64)
  );

  // Observed view of whichever instance is selected.
  logic        o_req_ready, o_resp_valid, o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready;
  logic [1:0]  o_resp_err;
  logic [63:0] o_resp_rdata, o_wdata, o_aw_pkt, o_ar_pkt;
  logic [8:0]  o_wctl;
  always_comb begin
    if (sel64) begin
      o_req_ready = req_ready64;  o_resp_valid = resp_valid64;
      o_resp_err = resp_err64;    o_resp_rdata = resp_rdata64;
      o_awvalid = bus64.awvalid;  o_wvalid = bus64.wvalid;  o_bready = bus64.bready;
      o_arvalid = bus64.arvalid;  o_rready = bus64.rready;  o_wdata = bus64.wdata;
      o_wctl = {bus64.wstrb, bus64.wlast};
      o_aw_pkt = {15'd0, bus64.awid, bus64.awsize, bus64.awlen, bus64.awburst, bus64.awaddr};
      o_ar_pkt = {15'd0, bus64.arid, bus64.arsize, bus64.arlen, bus64.arburst, bus64.araddr};
    end else begin
      o_req_ready = req_ready32;  o_resp_valid = resp_valid32;
      o_resp_err = resp_err32;    o_resp_rdata = {32'd0, resp_rdata32};
      o_awvalid = bus32.awvalid;  o_wvalid = bus32.wvalid;  o_bready = bus32.bready;
      o_arvalid = bus32.arvalid;  o_rready = bus32.rready;  o_wdata = {32'd0, bus32.wdata};
      o_wctl = {4'd0, bus32.wstrb, bus32.wlast};
      o_aw_pkt = {15'd0, bus32.awid, bus32.awsize, bus32.awlen, bus32.awburst, bus32.awaddr};
      o_ar_pkt = {15'd0, bus32.arid, bus32.arsize, bus32.arlen, bus32.arburst, bus32.araddr};
    end
  end

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  logic [3:0]  exp_id [2];
  logic [63:0] g_rdata;
  logic [1:0]  g_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain modular arithmetic on the bus word.
  function automatic logic [63:0] m_trunc(input logic [127:0] v, input int w);
    return (w == 64) ? v[63:0] : {32'd0, v[31:0]};
  endfunction

  function automatic logic [63:0] m_load(input logic [63:0] bus, input int lane, input int size,
                                         input bit uns, input int w);
    logic [127:0] v;
    int nb;
    nb = 8 << size;
    v  = {64'd0, m_trunc({64'd0, bus}, w)};
    v  = v >> (8 * lane);
    v  = v % (128'd1 << nb);
    if (!uns && v >= (128'd1 << (nb - 1))) v = v + (128'd1 << w) - (128'd1 << nb);
    return m_trunc(v, w);
  endfunction

  function automatic logic [63:0] m_wdata(input logic [63:0] wd, input int lane, input int w);
    logic [127:0] v;
    v = {64'd0, m_trunc({64'd0, wd}, w)};
    return m_trunc(v << (8 * lane), w);
  endfunction

  function automatic logic [7:0] m_strb(input int lane, input int size);
    return 8'(((1 << (1 << size)) - 1) << lane);
  endfunction

  task automatic idle_bus();
    awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
    bresp = 0; rresp = 0; bid = 0; rid = 0; rdata = 0;
  endtask

  // One request end to end. aw_d delays awready/arready, w_d delays wready, x_d delays bvalid/rvalid.
  task automatic txn(input bit s64, input logic [31:0] addr, input logic [63:0] wd, input bit wen,
                     input logic [1:0] size, input bit uns, input logic [63:0] rd,
                     input int aw_d, input int w_d, input int x_d, input bit bad_id,
                     input logic [1:0] xresp);
    int w, lane, nbytes, exp_lat, cyc, aw_c, w_c, ar_c, wait_n;
    bit legal, aw_s, w_s, b_s, ar_s, r_s;
    logic [3:0]  id;
    logic [1:0]  exp_err;
    logic [63:0] exp_rd;
    logic [4:0]  vec, exp_vec;
    w      = s64 ? 64 : 32;
    lane   = int'(addr % (w / 8));
    nbytes = 1 << size;
    legal  = (int'(size) <= (s64 ? 3 : 2)) && (lane % nbytes == 0);
    sel64  = s64;
    wait_n = 0;
    @(negedge clock);
    while (!o_req_ready && wait_n < 20) begin @(negedge clock); wait_n++; end
    chk("req_ready_idle", {63'd0, o_req_ready}, 64'd1);
    req_valid = 1; req_addr = addr; req_wdata = wd; req_wen = wen;
    req_size = size; req_unsigned = uns;
    @(posedge clock);
    #1 req_valid = 0;
    if (legal) exp_id[s64] = exp_id[s64] + 4'd1;
    id = exp_id[s64];
    if (!legal)              exp_err = 2'b01;
    else if (bad_id)         exp_err = 2'b11;
    else if (xresp != 2'b00) exp_err = 2'b10;
    else                     exp_err = 2'b00;
    exp_rd = (legal && !wen && exp_err == 2'b00) ? m_load(rd, lane, int'(size), uns, w) : 64'd0;
    if (!legal)  exp_lat = 2;
    else if (wen) exp_lat = ((aw_d > w_d) ? aw_d : w_d) + x_d + 3;
    else          exp_lat = aw_d + x_d + 3;
    aw_s = 0; w_s = 0; b_s = 0; ar_s = 0; r_s = 0; aw_c = 0; w_c = 0; ar_c = 0;
    cyc = 0;
    while (cyc < 40) begin
      cyc++;
      @(negedge clock);
      if (o_resp_valid) break;
      vec     = {o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready};
      exp_vec = {wen && legal && !aw_s, wen && legal && !w_s, aw_s && w_s && !b_s,
                 !wen && legal && !ar_s, ar_s && !r_s};
      chk("valid_ready", {59'd0, vec}, {59'd0, exp_vec});
      if (o_awvalid)
        chk("aw_payload", o_aw_pkt, {15'd0, id, 1'b0, size, 8'd0, 2'b01, addr});
      if (o_wvalid) begin
        chk("w_data", o_wdata, m_wdata(wd, lane, w));
        chk("w_strb_last", {55'd0, o_wctl}, {55'd0, m_strb(lane, int'(size)), 1'b1});
      end
      if (o_arvalid)
        chk("ar_payload", o_ar_pkt, {15'd0, id, 1'b0, size, 8'd0, 2'b01, addr});
      awready = (cyc >= 1 + aw_d);
      wready  = (cyc >= 1 + w_d);
      arready = (cyc >= 1 + aw_d);
      bvalid  = (aw_s && w_s && cyc >= ((aw_c > w_c) ? aw_c : w_c) + 1 + x_d) || !wen;
      bid     = bad_id ? id + 4'd1 : id;
      bresp   = xresp;
      rvalid  = ar_s && (cyc >= ar_c + 1 + x_d);
      rid     = bad_id ? id + 4'd1 : id;
      rresp   = xresp;
      rdata   = rd;
      @(posedge clock);
      if (vec[4] && awready) begin aw_s = 1; aw_c = cyc; end
      if (vec[3] && wready)  begin w_s = 1;  w_c = cyc;  end
      if (vec[2] && bvalid)  b_s = 1;
      if (vec[1] && arready) begin ar_s = 1; ar_c = cyc; end
      if (vec[0] && rvalid)  r_s = 1;
    end
    chk("resp_latency", 64'(cyc), 64'(exp_lat));
    chk("resp_err", {61'd0, o_resp_valid, o_resp_err}, {61'd0, 1'b1, exp_err});
    chk("resp_rdata", o_resp_rdata, exp_rd);
    chk("req_ready_in_resp", {63'd0, o_req_ready}, 64'd0);
    g_rdata = o_resp_rdata;
    g_err   = o_resp_err;
    idle_bus();
    @(negedge clock);
    chk("resp_one_cycle", {63'd0, o_resp_valid}, 64'd0);
    chk("req_ready_after_resp", {63'd0, o_req_ready}, 64'd1);
  endtask

  initial begin
    bit          s, wn, un, bad;
    logic [1:0]  sz, xr;
    int          ln;
    logic [31:0] ad;
    reset = 0; sel64 = 0; req_valid = 0; req_addr = 0; req_wdata = 0;
    req_wen = 0; req_size = 0; req_unsigned = 0;
    exp_id[0] = 0; exp_id[1] = 0;
    idle_bus();

    // Clock/reset: outputs idle while held, ready appears one edge after release.
    repeat (2) @(negedge clock);
    chk("reset_outputs32", {55'd0, o_req_ready, o_resp_valid, o_resp_err, o_awvalid, o_wvalid,
                            o_bready, o_arvalid, o_rready}, 64'd0);
    sel64 = 1; #1;
    chk("reset_outputs64", {55'd0, o_req_ready, o_resp_valid, o_resp_err, o_awvalid, o_wvalid,
                            o_bready, o_arvalid, o_rready}, 64'd0);
    @(negedge clock) reset = 1;
    @(negedge clock);
    chk("req_ready_after_reset", {63'd0, o_req_ready}, 64'd1);

    // Byte store at the top lane of a 32-bit bus.
    txn(0, 32'h8000_0003, 64'hAB, 1, 2'd0, 0, 64'd0, 0, 0, 0, 0, 2'b00);
    chk("store_b_err", {62'd0, g_err}, 64'd0);

    // Halfword loads from lane 2, signed and unsigned.
    txn(0, 32'h1000_0002, 64'd0, 0, 2'd1, 0, 64'h8001_1234, 0, 0, 0, 0, 2'b00);
    chk("load_h_signed", g_rdata, 64'h0000_0000_FFFF_8001);
    txn(0, 32'h1000_0002, 64'd0, 0, 2'd1, 1, 64'h8001_1234, 0, 0, 0, 0, 2'b00);
    chk("load_h_unsigned", g_rdata, 64'h0000_0000_0000_8001);

    // 64-bit bus: full doubleword and signed upper word.
    txn(1, 32'h2000_0008, 64'd0, 0, 2'd3, 0, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 0, 2'b00);
    chk("load_d_64", g_rdata, 64'h0123_4567_89AB_CDEF);
    txn(1, 32'h2000_0004, 64'd0, 0, 2'd2, 0, 64'h8000_0000_1111_2222, 0, 0, 0, 0, 2'b00);
    chk("load_w_signed_64", g_rdata, 64'hFFFF_FFFF_8000_0000);

    // Illegal requests: misaligned word and doubleword on a 32-bit bus.
    txn(0, 32'h3000_0002, 64'h55, 0, 2'd2, 0, 64'd0, 0, 0, 0, 0, 2'b00);
    chk("misaligned_w", {62'd0, g_err}, 64'd1);
    txn(0, 32'h3000_0000, 64'h55, 1, 2'd3, 0, 64'd0, 0, 0, 0, 0, 2'b00);
    chk("size_d_on_32", {62'd0, g_err}, 64'd1);

    // Delayed awready with SLVERR, then a wrong bid, then a failed load returning zero data.
    txn(0, 32'h0000_0040, 64'h1234_5678, 1, 2'd2, 0, 64'd0, 3, 0, 0, 0, 2'b10);
    chk("store_slverr", {62'd0, g_err}, 64'd2);
    txn(0, 32'h0000_0044, 64'h9ABC_DEF0, 1, 2'd2, 0, 64'd0, 0, 2, 1, 1, 2'b00);
    chk("store_bad_bid", {62'd0, g_err}, 64'd3);
    txn(1, 32'h0000_0048, 64'd0, 0, 2'd2, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 2, 0, 2'b10);
    chk("load_err_zero_data", g_rdata, 64'd0);

    // Reset in the middle of a load with rvalid pending.
    sel64 = 1;
    @(negedge clock);
    req_valid = 1; req_addr = 32'h100; req_wen = 0; req_size = 2'd2; req_unsigned = 0;
    @(posedge clock);
    #1 req_valid = 0;
    arready = 1;
    @(negedge clock);
    chk("abort_arvalid", {63'd0, o_arvalid}, 64'd1);
    @(negedge clock);
    chk("abort_rready", {63'd0, o_rready}, 64'd1);
    rvalid = 1; rdata = 64'h1; rid = 4'd7;
    #2 reset = 0;
    #1;
    chk("async_reset_outputs", {55'd0, o_req_ready, o_resp_valid, o_resp_err, o_awvalid, o_wvalid,
                                o_bready, o_arvalid, o_rready}, 64'd0);
    chk("async_reset_rdata", o_resp_rdata, 64'd0);
    chk("async_reset_ar", {28'd0, o_ar_pkt[48:45], o_ar_pkt[31:0]}, 64'd0);
    @(negedge clock);
    idle_bus();
    reset = 1;
    exp_id[0] = 0; exp_id[1] = 0;
    txn(1, 32'h0000_0200, 64'h77, 1, 2'd0, 0, 64'd0, 0, 0, 0, 0, 2'b00);
    chk("id_restart", {60'd0, exp_id[1]}, 64'd1);

    // Randomized traffic on both bus widths.
    for (int k = 0; k < 80; k++) begin
      s  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      wn = 1'($urandom_range(0, 1));
      un = 1'($urandom_range(0, 1));
      bad = ($urandom_range(0, 7) == 0);
      xr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      ln = int'($urandom_range(0, s ? 7 : 3));
      if ($urandom_range(0, 3) != 0) ln = (ln >> sz) << sz;
      ad = ($urandom & 32'hFFFF_FFF8) | 32'(ln);
      txn(s, ad, {$urandom, $urandom}, wn, sz, un, {$urandom, $urandom},
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
          bad, xr);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
